// File: rtl/idma_chan_scheduler.sv
// Round-robin share of one iDMA backend port among NumChan channels: credits, a registered output slice
// (1-cycle grant->valid, AXI-stable until ready_i) and an in-order retire FIFO. Option: IDMA_CHAN_SCHED_PRIO_EN.
module idma_chan_scheduler #(
  parameter int unsigned NumChan        = 4,
  parameter int unsigned ChanCredits    = 2,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned IdCounterWidth = 32,
  parameter type         burst_req_t    = logic
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  burst_req_t                             chan_req_i [NumChan],
  input  logic [NumChan-1:0]                     chan_valid_i,
  output logic [NumChan-1:0]                     chan_ready_o,
  output burst_req_t                             burst_req_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  input  logic                                   trans_complete_i,
  input  logic                                   drain_i,
`ifdef IDMA_CHAN_SCHED_PRIO_EN
  input  logic [NumChan-1:0]                     prio_i,
`endif
  output logic [NumChan-1:0][IdCounterWidth-1:0] chan_done_o,
  output logic [NumChan-1:0]                     chan_busy_o,
  output logic                                   idle_o,
  output logic                                   err_o
);

  localparam int unsigned ChIdxW = $clog2(NumChan);
  localparam int unsigned CredW  = $clog2(ChanCredits + 1);
  localparam int unsigned PtrW   = $clog2(MaxOutstanding);
  localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);

  typedef enum logic {SlotIdle, SlotHold} slot_state_e;

  slot_state_e                            state_q, state_d;
  burst_req_t                             req_q, req_d;
  logic [ChIdxW-1:0]                      slot_chan_q, slot_chan_d;
  logic [ChIdxW-1:0]                      rr_q, rr_d;
  logic [CredW-1:0]                       credit_q [NumChan];
  logic [CredW-1:0]                       credit_d [NumChan];
  logic [NumChan-1:0][IdCounterWidth-1:0] done_q, done_d;
  logic [ChIdxW-1:0]                      fifo_mem_q [MaxOutstanding];
  logic [PtrW-1:0]                        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                        cnt_q, cnt_d;
  logic                                   err_q, err_d;

  logic               slot_free, room, grant, push, pop, fifo_empty, fifo_wr, fifo_rd;
  logic [NumChan-1:0] elig, cand;
  logic [ChIdxW-1:0]  gnt_idx, head_idx;

  assign valid_o     = (state_q == SlotHold);
  assign burst_req_o = req_q;
  assign chan_done_o = done_q;
  assign err_o       = err_q;
  assign fifo_empty  = (cnt_q == '0);
  assign idle_o      = !valid_o && fifo_empty;
  assign slot_free   = !valid_o || ready_i;

  // The occupied slot already holds a reservation, so it counts against the global limit.
  assign room = ({1'b0, cnt_q} + {{CntW{1'b0}}, valid_o}) < (CntW+1)'(MaxOutstanding);

  always_comb begin
    for (int c = 0; c < int'(NumChan); c++) begin
      elig[c]        = chan_valid_i[c] && (credit_q[c] < CredW'(ChanCredits)) && !drain_i && room;
      chan_busy_o[c] = (credit_q[c] != '0);
    end
  end

`ifdef IDMA_CHAN_SCHED_PRIO_EN
  assign cand = (|(elig & prio_i)) ? (elig & prio_i) : elig;
`else
  assign cand = elig;
`endif

  always_comb begin
    logic [ChIdxW:0]   sum;
    logic [ChIdxW-1:0] idx;
    grant   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < int'(NumChan); i++) begin
      sum = {1'b0, rr_q} + (ChIdxW+1)'(i);
      if (sum >= (ChIdxW+1)'(NumChan)) sum = sum - (ChIdxW+1)'(NumChan);
      idx = sum[ChIdxW-1:0];
      if (!grant && slot_free && cand[idx]) begin
        grant   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    chan_ready_o = '0;
    if (grant && !rst_i) chan_ready_o[gnt_idx] = 1'b1;
  end

  // A completion arriving while the FIFO is empty but the slot is issuing retires that slot directly.
  assign push     = valid_o && ready_i;
  assign pop      = trans_complete_i && (!fifo_empty || push);
  assign head_idx = fifo_empty ? slot_chan_q : fifo_mem_q[rd_ptr_q];
  assign fifo_wr  = push && !(pop && fifo_empty);
  assign fifo_rd  = pop && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    slot_chan_d = slot_chan_q;
    rr_d        = rr_q;
    case (state_q)
      SlotIdle: if (grant) state_d = SlotHold;
      SlotHold: if (ready_i && !grant) state_d = SlotIdle;
      default:  state_d = SlotIdle;
    endcase
    if (grant) begin
      req_d       = chan_req_i[gnt_idx];
      slot_chan_d = gnt_idx;
      rr_d        = (gnt_idx == ChIdxW'(NumChan - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NumChan); c++) begin
      credit_d[c] = credit_q[c];
      done_d[c]   = done_q[c];
      if (grant && (gnt_idx == ChIdxW'(c))) credit_d[c] = credit_d[c] + 1'b1;
      if (pop && (head_idx == ChIdxW'(c))) begin
        credit_d[c] = credit_d[c] - 1'b1;
        done_d[c]   = done_q[c] + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({fifo_wr, fifo_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (trans_complete_i && !pop) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SlotIdle;
      req_q       <= '0;
      slot_chan_q <= '0;
      rr_q        <= '0;
      done_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      for (int c = 0; c < int'(NumChan); c++) credit_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      slot_chan_q <= slot_chan_d;
      rr_q        <= rr_d;
      done_q      <= done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      credit_q    <= credit_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= slot_chan_q;
  end

endmodule

// File: tb/tb_idma_chan_scheduler.sv
// Bench for idma_chan_scheduler: queue-based reference model checked every cycle, plus directed literal checks.
module tb_idma_chan_scheduler;
  localparam int NC = 4;
  localparam int CC = 2;
  localparam int MO = 8;
  localparam int DW = 32;
  typedef logic [15:0] req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  req_t                 chan_req [NC];
  logic [NC-1:0]        chan_valid, chan_ready, busy;
  req_t                 burst_req;
  logic                 valid, ready, tc, drain, idle, err;
  logic [NC-1:0][DW-1:0] done;
`ifdef IDMA_CHAN_SCHED_PRIO_EN
  logic [NC-1:0]        prio;
`endif

  idma_chan_scheduler #(.NumChan(NC), .ChanCredits(CC), .MaxOutstanding(MO), .IdCounterWidth(DW),
                        .burst_req_t(req_t)) dut (
    .clk_i(clk), .rst_i(rst), .chan_req_i(chan_req), .chan_valid_i(chan_valid), .chan_ready_o(chan_ready),
    .burst_req_o(burst_req), .valid_o(valid), .ready_i(ready), .trans_complete_i(tc), .drain_i(drain),
`ifdef IDMA_CHAN_SCHED_PRIO_EN
    .prio_i(prio),
`endif
    .chan_done_o(done), .chan_busy_o(busy), .idle_o(idle), .err_o(err));

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents plus a queue of issued channel ids; credits are derived by counting.
  bit          m_slot;
  req_t        m_data;
  int          m_slot_ch;
  int          m_q[$];
  int          m_rr;
  logic [DW-1:0] m_done [NC];
  bit          m_err;
  int          glog[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_credit(input int c);
    int n;
    n = (m_slot && m_slot_ch == c) ? 1 : 0;
    foreach (m_q[i]) if (m_q[i] == c) n++;
    return n;
  endfunction

  task automatic model_clear();
    m_slot = 0; m_data = '0; m_slot_ch = 0; m_q.delete(); m_rr = 0; m_err = 0;
    for (int c = 0; c < NC; c++) m_done[c] = '0;
  endtask

  task automatic rand_payload();
    for (int c = 0; c < NC; c++) chan_req[c] = 16'($urandom);
  endtask

  // Called at posedge+1 with inputs set; compares at posedge+5, advances the model, returns at next posedge+1.
  task automatic step();
    int g, h;
    bit room;
    logic [NC-1:0] elig, cand, exp_rdy;
    #4;
    room = (m_q.size() + int'(m_slot)) < MO;
    for (int c = 0; c < NC; c++) elig[c] = chan_valid[c] && (m_credit(c) < CC) && !drain && room;
    cand = elig;
`ifdef IDMA_CHAN_SCHED_PRIO_EN
    if ((elig & prio) != '0) cand = elig & prio;
`endif
    g = -1;
    if (!m_slot || ready)
      for (int i = 0; i < NC; i++)
        if (g < 0 && cand[(m_rr + i) % NC]) g = (m_rr + i) % NC;
    exp_rdy = '0;
    if (g >= 0 && !rst) exp_rdy[g] = 1'b1;
    check("chan_ready", chan_ready, exp_rdy);
    check("valid", valid, m_slot);
    check("burst_req", burst_req, m_data);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("done%0d", c), done[c], m_done[c]);
      check($sformatf("busy%0d", c), busy[c], m_credit(c) != 0);
    end
    check("idle", idle, !m_slot && m_q.size() == 0);
    check("err", err, m_err);
    if (rst) begin
      model_clear();
    end else begin
      if (m_slot && ready) begin
        m_q.push_back(m_slot_ch);
        m_slot = 0;
      end
      if (tc) begin
        if (m_q.size() > 0) begin
          h = m_q.pop_front();
          m_done[h] = m_done[h] + 1;
        end else begin
          m_err = 1;
        end
      end
      if (g >= 0) begin
        m_slot = 1; m_data = chan_req[g]; m_slot_ch = g; m_rr = (g + 1) % NC;
        glog.push_back(g);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; chan_valid = '0; ready = 0; tc = 0; drain = 0;
`ifdef IDMA_CHAN_SCHED_PRIO_EN
    prio = '0;
`endif
    rand_payload();
    step();
    rst = 0;
    glog.delete();
  endtask

  initial begin
    int exp_seq [8];
    int n;
    req_t held;
    rst = 1; chan_valid = '0; ready = 0; tc = 0; drain = 0;
`ifdef IDMA_CHAN_SCHED_PRIO_EN
    prio = '0;
`endif
    rand_payload();
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    check("rst_idle", idle, 1);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);

    // All four channels valid, completions as soon as anything is outstanding.
    chan_valid = 4'hF; ready = 1;
    for (int k = 0; k < 10; k++) begin
      rand_payload();
      tc = (m_q.size() > 0);
      step();
    end
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    check("rr_len", glog.size() >= 8, 1);
    if (glog.size() >= 8)
      for (int k = 0; k < 8; k++) check($sformatf("rr_seq%0d", k), glog[k], exp_seq[k]);

    // Single channel runs out of credits.
    do_reset();
    chan_valid = 4'b0010; ready = 1;
    for (int k = 0; k < 6; k++) begin rand_payload(); step(); end
    check("ch1_grants", glog.size(), 2);
    tc = 1; step(); tc = 0;
    for (int k = 0; k < 3; k++) step();
    check("ch1_regrant", glog.size(), 3);

    // Backpressure holds the slot stable.
    do_reset();
    chan_valid = 4'b0001; ready = 0;
    rand_payload();
    held = chan_req[0];
    step();
    for (int k = 0; k < 5; k++) begin rand_payload(); step(); end
    check("hold_data", burst_req, held);
    check("hold_grants", glog.size(), 1);
    ready = 1; step();
    check("issue_regrant", glog.size(), 2);

    // Issue ch2, ch0, ch2 then retire all three.
    do_reset();
    ready = 1;
    chan_valid = 4'b0100; step();
    chan_valid = 4'b0001; step();
    chan_valid = 4'b0100; step();
    chan_valid = 4'b0000; step();
    check("ord_len", glog.size(), 3);
    if (glog.size() == 3) begin
      check("ord0", glog[0], 2); check("ord1", glog[1], 0); check("ord2", glog[2], 2);
    end
    tc = 1;
    for (int k = 0; k < 3; k++) step();
    tc = 0; step();
    check("done2", done[2], 2);
    check("done0", done[0], 1);
    check("busy_clear", busy, 0);
    check("idle_after", idle, 1);

    // Drain with a full slot.
    do_reset();
    chan_valid = 4'hF; ready = 1;
    step(); step();
    ready = 0; step();
    drain = 1; step(); step();
    ready = 1;
    for (int k = 0; k < 4; k++) step();
    check("drain_grants", glog.size(), 2);
    tc = 1;
    for (int k = 0; k < 10 && m_q.size() > 0; k++) step();
    tc = 0; step();
    check("drain_idle", idle, 1);
    check("drain_noerr", err, 0);
    tc = 1; step(); tc = 0; step();
    check("extra_err", err, 1);
    drain = 0;

`ifdef IDMA_CHAN_SCHED_PRIO_EN
    do_reset();
    chan_valid = 4'hF; ready = 1; prio = 4'b1000;
    for (int k = 0; k < 4; k++) step();
    check("prio_len", glog.size() >= 3, 1);
    if (glog.size() >= 3) begin
      check("prio0", glog[0], 3); check("prio1", glog[1], 3); check("prio2", glog[2], 0);
    end
`endif

    // Randomized traffic, including bypass completions, drains and mid-run resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rand_payload();
      chan_valid = 4'($urandom);
      ready = ($urandom % 4) != 0;
      drain = ($urandom % 16) == 0;
      if (m_q.size() > 0 || (m_slot && ready)) tc = ($urandom % 3) == 0;
      else tc = ($urandom % 50) == 0;
      rst = ($urandom % 500) == 0;
`ifdef IDMA_CHAN_SCHED_PRIO_EN
      prio = 4'($urandom);
`endif
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
